issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue_pkg.sv | 37 +++
 rtl/issue_queue_select.sv | 63 ++++++
 rtl/issue_queue.sv | 157 +++++++++++++++
 tb/tb_issue_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// issue_queue_pkg
//   Shared types and constants for the issue queue and its window selector.
//   - e_issue_unit : target unit code carried by each queued instruction
//   - issue_entry  : control part of a queue entry (address fields are kept in
//                    parallel arrays in the top so they can follow ADDR_W)
//   - e_iq_state   : RUN / DRAIN / DONE end-of-program sequencing
// -----------------------------------------------------------------------------
package issue_queue_pkg;

   localparam int ISSUE_UNITS = 3;   // LDST, ARITH, RAM
   localparam int INSTR_W     = 16;
   localparam int COPY_W      = 3;   // copies_m1 / copy index width (1..8 copies)
   localparam int WIN         = 3;   // issue window: oldest three entries
   localparam int SLOT_W      = 2;   // window slot index width

   typedef enum logic [1:0] {
      UNIT_LDST  = 2'd0,
      UNIT_ARITH = 2'd1,
      UNIT_RAM   = 2'd2,
      UNIT_ILL   = 2'd3
   } e_issue_unit;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      e_issue_unit        unit;
      logic [COPY_W-1:0]  copies_m1;
      logic [COPY_W-1:0]  k;          // next copy to issue
   } issue_entry;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } e_iq_state;

endpackage

// File: rtl/issue_queue_select.sv
// -----------------------------------------------------------------------------
// issue_select
//   Combinational scan of the issue window (oldest entry in slot 0).
//   Ports:
//     slot_valid  in  WIN        slot holds a queued entry
//     slot_unit   in  WIN x 2    unit code of each slot
//     slot_final  in  WIN        slot's next copy is its last one
//     ready       in  UNITS      per-unit issue ready
//     grant       out UNITS      per-unit issue valid
//     slot_idx    out UNITS x 2  window slot feeding each granted unit
//     retire      out WIN        slots leaving the queue this cycle (prefix)
// -----------------------------------------------------------------------------
module issue_select
   import issue_queue_pkg::*;
(
   input  logic [WIN-1:0]                     slot_valid,
   input  logic [WIN-1:0][1:0]                slot_unit,
   input  logic [WIN-1:0]                     slot_final,
   input  logic [ISSUE_UNITS-1:0]             ready,
   output logic [ISSUE_UNITS-1:0]             grant,
   output logic [ISSUE_UNITS-1:0][SLOT_W-1:0] slot_idx,
   output logic [WIN-1:0]                     retire
);

   logic [ISSUE_UNITS-1:0] claimed;
   logic                   chain;   // every older slot finishes this cycle
   logic [1:0]             u;

   // A younger slot may only issue when all older slots retire this cycle.
   // The older slots' completion depends only on their own units' ready, and
   // those units differ from the younger slot's unit, so grant[u] never looks
   // at ready[u].
   always_comb begin
      grant    = '0;
      slot_idx = '0;
      retire   = '0;
      claimed  = '0;
      chain    = 1'b1;
      u        = '0;
      for (int j = 0; j < WIN; j++) begin
         u = slot_unit[j];
         if (chain && slot_valid[j]) begin
            if (u == UNIT_ILL) begin
               // illegal entry drops out only from the head, and always
               // stalls everything younger for this cycle
               retire[j] = (j == 0);
               chain     = 1'b0;
            end else if (claimed[u]) begin
               chain = 1'b0;
            end else begin
               grant[u]    = 1'b1;
               slot_idx[u] = SLOT_W'(j);
               claimed[u]  = 1'b1;
               retire[j]   = ready[u] && slot_final[j];
               chain       = retire[j];
            end
         end else begin
            chain = 1'b0;
         end
      end
   end

endmodule

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
//   Circular instruction queue between the control unit and three execution
//   units. Each entry expands into 1..8 superscalar copies, copy k addressed
//   at base + k*stride. Issue is strictly in program order over a 3-entry
//   window, at most one copy per unit per cycle.
//   Ports:
//     clk, reset                 clock, async active-low reset
//     push_valid/push_ready      push handshake from the control unit
//     push_instr/unit/copies_m1  instruction word, target unit, copies-1
//     push_base/push_stride      copy 0 address and per-copy increment
//     iss_valid/iss_ready        per-unit issue handshake (index = unit code)
//     iss_instr/iss_addr/iss_copy per-unit instruction, copy address, copy idx
//     drain/done                 end-of-program request / completion pulse
//     count                      occupancy
//     err_illegal                sticky: an illegal-unit entry was accepted
// -----------------------------------------------------------------------------
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter  int DEPTH     = 16,
   parameter  int ADDR_W    = 18,
   localparam int LOG_DEPTH = $clog2(DEPTH)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               push_valid,
   output logic                               push_ready,
   input  logic [INSTR_W-1:0]                 push_instr,
   input  logic [1:0]                         push_unit,
   input  logic [COPY_W-1:0]                  push_copies_m1,
   input  logic [ADDR_W-1:0]                  push_base,
   input  logic [ADDR_W-1:0]                  push_stride,
   output logic [ISSUE_UNITS-1:0]             iss_valid,
   input  logic [ISSUE_UNITS-1:0]             iss_ready,
   output logic [ISSUE_UNITS-1:0][INSTR_W-1:0] iss_instr,
   output logic [ISSUE_UNITS-1:0][ADDR_W-1:0] iss_addr,
   output logic [ISSUE_UNITS-1:0][COPY_W-1:0] iss_copy,
   input  logic                               drain,
   output logic                               done,
   output logic [LOG_DEPTH:0]                 count,
   output logic                               err_illegal
);

   // ---------------------------------------------------------------- storage
   issue_entry           ent      [DEPTH];
   logic [ADDR_W-1:0]    base_q   [DEPTH];
   logic [ADDR_W-1:0]    stride_q [DEPTH];
   logic [LOG_DEPTH-1:0] head, tail;
   e_iq_state            state, state_nxt;

   // ---------------------------------------------------------------- window
   logic [WIN-1:0][LOG_DEPTH-1:0]         win_ptr;
   logic [WIN-1:0]                        slot_valid;
   logic [WIN-1:0][1:0]                   slot_unit;
   logic [WIN-1:0]                        slot_final;
   logic [ISSUE_UNITS-1:0]                grant;
   logic [ISSUE_UNITS-1:0][SLOT_W-1:0]    sel_slot;
   logic [WIN-1:0]                        retire;
   logic [ISSUE_UNITS-1:0][LOG_DEPTH-1:0] uptr;
   logic [ISSUE_UNITS-1:0]                fire;
   logic [1:0]                            n_retire;
   logic                                  push_fire;

   for (genvar j = 0; j < WIN; j++) begin : g_win
      assign win_ptr[j]    = head + LOG_DEPTH'(j);
      assign slot_valid[j] = count > (LOG_DEPTH+1)'(j);
      assign slot_unit[j]  = ent[win_ptr[j]].unit;
      assign slot_final[j] = ent[win_ptr[j]].k == ent[win_ptr[j]].copies_m1;
   end

   issue_select u_select (
      .slot_valid (slot_valid),
      .slot_unit  (slot_unit),
      .slot_final (slot_final),
      .ready      (iss_ready),
      .grant      (grant),
      .slot_idx   (sel_slot),
      .retire     (retire)
   );

   // ---------------------------------------------------------------- issue
   for (genvar u = 0; u < ISSUE_UNITS; u++) begin : g_unit
      assign uptr[u]      = win_ptr[sel_slot[u]];
      assign iss_valid[u] = grant[u];
      assign fire[u]      = grant[u] & iss_ready[u];
      assign iss_instr[u] = ent[uptr[u]].instr;
      assign iss_copy[u]  = ent[uptr[u]].k;
      // product truncated to ADDR_W: addresses wrap modulo 2^ADDR_W
      assign iss_addr[u]  = base_q[uptr[u]]
                          + ADDR_W'(ent[uptr[u]].k) * stride_q[uptr[u]];
   end

   // retire is always a contiguous prefix of the window
   assign n_retire = 2'(retire[0]) + 2'(retire[1]) + 2'(retire[2]);

   // Full queue stays closed even if the head pops this cycle: no bypass.
   assign push_ready = reset && (state == ST_RUN)
                    && (count < (LOG_DEPTH+1)'(DEPTH));
   assign push_fire  = push_valid && push_ready;

   // ---------------------------------------------------------------- queue state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         err_illegal <= 1'b0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         // copy counters advance on transfer; a retiring entry's k is left
         // stale and overwritten by its next push
         for (int u = 0; u < ISSUE_UNITS; u++) begin
            if (fire[u]) ent[uptr[u]].k <= ent[uptr[u]].k + COPY_W'(1);
         end
         // tail slot is never occupied when push_ready is high, so this
         // write cannot collide with a k update above
         if (push_fire) begin
            ent[tail] <= '{instr:     push_instr,
                           unit:      e_issue_unit'(push_unit),
                           copies_m1: push_copies_m1,
                           k:         '0};
            tail <= tail + LOG_DEPTH'(1);
            if (push_unit == UNIT_ILL) err_illegal <= 1'b1;
         end
         head  <= head + LOG_DEPTH'(n_retire);
         count <= count + (LOG_DEPTH+1)'(push_fire) - (LOG_DEPTH+1)'(n_retire);
      end
   end

   // address fields carry no state worth clearing
   always_ff @(posedge clk) begin
      if (push_fire) begin
         base_q[tail]   <= push_base;
         stride_q[tail] <= push_stride;
      end
   end

   // ---------------------------------------------------------------- drain FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (drain) state_nxt = ST_DRAIN;
         ST_DRAIN: if (count == '0) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
//   Directed scenarios with literal expectations, followed by a long random
//   run. A queue-based reference model tracks every accepted instruction and
//   its issued copies; one negedge process compares all outputs each cycle.
// -----------------------------------------------------------------------------
module tb_issue_queue;
   import issue_queue_pkg::*;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 18;
   localparam int AMASK  = (1 << ADDR_W) - 1;

   logic                               clk = 1'b0;
   logic                               reset = 1'b1;
   logic                               push_valid = 1'b0;
   logic                               push_ready;
   logic [INSTR_W-1:0]                 push_instr = '0;
   logic [1:0]                         push_unit = '0;
   logic [COPY_W-1:0]                  push_copies_m1 = '0;
   logic [ADDR_W-1:0]                  push_base = '0;
   logic [ADDR_W-1:0]                  push_stride = '0;
   logic [ISSUE_UNITS-1:0]             iss_valid;
   logic [ISSUE_UNITS-1:0]             iss_ready = '0;
   logic [ISSUE_UNITS-1:0][INSTR_W-1:0] iss_instr;
   logic [ISSUE_UNITS-1:0][ADDR_W-1:0] iss_addr;
   logic [ISSUE_UNITS-1:0][COPY_W-1:0] iss_copy;
   logic                               drain = 1'b0;
   logic                               done;
   logic [4:0]                         count;
   logic                               err_illegal;

   issue_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .push_valid     (push_valid),
      .push_ready     (push_ready),
      .push_instr     (push_instr),
      .push_unit      (push_unit),
      .push_copies_m1 (push_copies_m1),
      .push_base      (push_base),
      .push_stride    (push_stride),
      .iss_valid      (iss_valid),
      .iss_ready      (iss_ready),
      .iss_instr      (iss_instr),
      .iss_addr       (iss_addr),
      .iss_copy       (iss_copy),
      .drain          (drain),
      .done           (done),
      .count          (count),
      .err_illegal    (err_illegal)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, $time, act, act, exp, exp);
      end
   endtask

   // ------------------------------------------------------------ reference model
   typedef struct {
      int instr;
      int unit;
      int cm1;
      int base;
      int stride;
      int k;
   } m_ent_t;

   m_ent_t mq[$];
   int     m_mode = 0;   // 0 run, 1 draining, 2 done pulse
   bit     m_err  = 0;

   // Outputs are stable from posedge+1 (inputs driven) to the next posedge.
   // Check at negedge, then advance the model across the coming posedge.
   always @(negedge clk) begin : cmp
      int         n, nret, u, a;
      bit         ok, pr_exp;
      bit         isw [3];
      logic [2:0] ev;
      m_ent_t     e;
      if (!reset) begin
         mq.delete();
         m_mode = 0;
         m_err  = 0;
         chk("rst_count",      int'(count),       0);
         chk("rst_iss_valid",  int'(iss_valid),   0);
         chk("rst_push_ready", int'(push_ready),  0);
         chk("rst_done",       int'(done),        0);
         chk("rst_err",        int'(err_illegal), 0);
      end else begin
         n  = (mq.size() < 3) ? mq.size() : 3;
         ev = '0;
         // an entry issues when it is legal and every older window entry is
         // itself issuing, on another unit, and sending its last copy now
         for (int j = 0; j < 3; j++) begin
            isw[j] = 0;
            if (j < n && mq[j].unit != 3) begin
               ok = 1;
               for (int i = 0; i < j; i++)
                  if (!isw[i] || mq[i].unit == mq[j].unit ||
                      !iss_ready[mq[i].unit] || mq[i].k != mq[i].cm1) ok = 0;
               isw[j] = ok;
               if (ok) ev[mq[j].unit] = 1'b1;
            end
         end
         pr_exp = (mq.size() < DEPTH) && (m_mode == 0);
         chk("push_ready",  int'(push_ready),  int'(pr_exp));
         chk("count",       int'(count),       mq.size());
         chk("done",        int'(done),        int'(m_mode == 2));
         chk("err_illegal", int'(err_illegal), int'(m_err));
         chk("iss_valid",   int'(iss_valid),   int'(ev));
         for (int j = 0; j < n; j++) begin
            if (isw[j]) begin
               u = mq[j].unit;
               a = (mq[j].base + mq[j].k * mq[j].stride) & AMASK;
               chk("iss_instr", int'(iss_instr[u]), mq[j].instr);
               chk("iss_addr",  int'(iss_addr[u]),  a);
               chk("iss_copy",  int'(iss_copy[u]),  mq[j].k);
            end
         end
         // advance across the next rising edge
         case (m_mode)
            0:       if (drain) m_mode = 1;
            1:       if (mq.size() == 0) m_mode = 2;
            default: m_mode = 0;
         endcase
         nret = 0;
         for (int j = 0; j < n; j++) begin
            if (isw[j] && iss_ready[mq[j].unit]) begin
               if (mq[j].k == mq[j].cm1) nret++;
               else begin
                  e = mq[j]; e.k = e.k + 1; mq[j] = e;
               end
            end
         end
         if (n > 0 && mq[0].unit == 3) nret = 1;
         for (int r = 0; r < nret; r++) void'(mq.pop_front());
         if (push_valid && pr_exp) begin
            e.instr  = int'(push_instr);
            e.unit   = int'(push_unit);
            e.cm1    = int'(push_copies_m1);
            e.base   = int'(push_base);
            e.stride = int'(push_stride);
            e.k      = 0;
            mq.push_back(e);
            if (push_unit == 2'd3) m_err = 1;
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int unit, input int cm1, input int base,
                        input int stride, input int instr);
      push_valid     = 1'b1;
      push_unit      = 2'(unit);
      push_copies_m1 = 3'(cm1);
      push_base      = ADDR_W'(base);
      push_stride    = ADDR_W'(stride);
      push_instr     = 16'(instr);
   endtask

   // returns at posedge+1 after the accepting edge with push_valid low
   task automatic push(input int unit, input int cm1, input int base,
                       input int stride, input int instr);
      int guard;
      guard = 0;
      drive(unit, cm1, base, stride, instr);
      while (!push_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) chk("push_timeout", 0, 1);
      tick();
      push_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int seen, cyc;
      #1 reset = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1;
      tick();

      // ---- four copies of one ARITH entry, addresses 100..112
      iss_ready = 3'b111;
      push(1, 3, 100, 4, 'h1111);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("arith_valid", int'(iss_valid), 2);
         chk("arith_addr",  int'(iss_addr[1]), 100 + 4 * c);
         chk("arith_copy",  int'(iss_copy[1]), c);
         tick();
      end
      #1 chk("arith_count_end", int'(count), 0);

      // ---- three units issue together, then two LDSTs in sequence
      iss_ready = 3'b000;
      push(0, 0, 10, 0, 'hA000);
      push(1, 0, 20, 0, 'hA001);
      push(2, 0, 30, 0, 'hA002);
      iss_ready = 3'b111;
      #1 chk("tri_issue", int'(iss_valid), 7);
      tick();
      #1 chk("tri_count", int'(count), 0);
      push(0, 0, 40, 0, 'hB000);
      drive(0, 0, 50, 0, 'hB001);
      #1 chk("ldst_first", int'(iss_instr[0]), 'hB000);
      tick();
      push_valid = 1'b0;
      #1 chk("ldst_second", int'(iss_instr[0]), 'hB001);
      chk("ldst_second_v", int'(iss_valid), 1);
      tick();

      // ---- fill to full, one pop, then the held push goes in
      iss_ready = 3'b000;
      for (int i = 0; i < DEPTH; i++) push(1, 0, i, 1, 'h200 + i);
      #1;
      chk("full_ready", int'(push_ready), 0);
      chk("full_count", int'(count), 16);
      drive(1, 0, 77, 1, 'h2FF);
      iss_ready = 3'b010;
      tick();
      iss_ready = 3'b000;
      #1;
      chk("after_pop_ready", int'(push_ready), 1);
      chk("after_pop_count", int'(count), 15);
      tick();
      push_valid = 1'b0;
      #1 chk("refill_count", int'(count), 16);
      iss_ready = 3'b111;
      repeat (18) tick();
      #1 chk("full_drained", int'(count), 0);

      // ---- address wraps modulo 2^18
      push(1, 1, 'h3FFFF, 1, 'hC000);
      #1 chk("wrap_addr0", int'(iss_addr[1]), 'h3FFFF);
      tick();
      #1 chk("wrap_addr1", int'(iss_addr[1]), 0);
      tick();

      // ---- illegal unit, then ARITH behind it
      push(3, 0, 0, 0, 'hBAD);
      drive(1, 0, 5, 0, 'hD000);
      #1;
      chk("ill_err", int'(err_illegal), 1);
      chk("ill_no_issue", int'(iss_valid), 0);
      tick();
      push_valid = 1'b0;
      #1 chk("ill_then_arith", int'(iss_valid), 2);
      tick(); tick();
      #1 chk("ill_sticky", int'(err_illegal), 1);

      // ---- drain while empty: done two cycles after drain is sampled
      drain = 1'b1;
      tick();
      drain = 1'b0;
      tick();
      #1 chk("drain_empty_done", int'(done), 1);
      tick();
      #1 chk("drain_empty_pulse", int'(done), 0);

      // ---- drain with three queued entries
      iss_ready = 3'b000;
      push(1, 0, 1, 0, 'hE000);
      push(1, 0, 2, 0, 'hE001);
      push(1, 0, 3, 0, 'hE002);
      drain = 1'b1;
      tick();
      drain = 1'b0;
      #1 chk("drain_blocks_push", int'(push_ready), 0);
      iss_ready = 3'b111;
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < 20) begin
         tick();
         cyc++;
         #1 if (done) seen = 1;
      end
      chk("drain_done_seen", seen, 1);
      chk("drain_done_count", int'(count), 0);
      tick();
      #1 chk("drain_done_pulse", int'(done), 0);
      chk("drain_back_run", int'(push_ready), 1);

      // ---- reset with entries queued
      iss_ready = 3'b000;
      push(0, 2, 1, 1, 'hF000);
      push(1, 2, 2, 1, 'hF001);
      push(2, 2, 3, 1, 'hF002);
      reset = 1'b0;
      #1;
      chk("midrst_count", int'(count), 0);
      chk("midrst_valid", int'(iss_valid), 0);
      tick(); tick();
      reset = 1'b1;
      tick();
      #1 chk("postrst_valid", int'(iss_valid), 0);

      // ---- random traffic
      for (int c = 0; c < 4000; c++) begin
         push_valid     = ($urandom_range(0, 99) < 60);
         push_unit      = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         push_copies_m1 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                       : 3'($urandom_range(0, 1));
         push_base      = ADDR_W'($urandom);
         push_stride    = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 8))
                                                      : ADDR_W'($urandom);
         push_instr     = 16'($urandom);
         for (int u = 0; u < 3; u++) iss_ready[u] = ($urandom_range(0, 99) < 65);
         drain          = ($urandom_range(0, 149) == 0);
         reset          = ($urandom_range(0, 599) != 0);
         tick();
      end
      push_valid = 1'b0;
      drain      = 1'b0;
      reset      = 1'b1;
      iss_ready  = 3'b111;
      repeat (40) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
